// File: rtl/marquee_scheduler_if.sv
// rtl/marquee_scheduler_if.sv - control inputs and pattern-select outputs of the marquee sequencer
interface marquee_scheduler_if;
  logic       pause;
  logic       skip_n;
  logic [1:0] mode;
  logic [4:0] step_idx;
  logic       step;
  logic       mode_start;

  // Sequencer side: consumes pause/skip, produces the pattern selection.
  modport master (
    input  pause,
    input  skip_n,
    output mode,
    output step_idx,
    output step,
    output mode_start
  );

  // Board/datapath side: drives pause/skip, consumes the pattern selection.
  modport slave (
    output pause,
    output skip_n,
    input  mode,
    input  step_idx,
    input  step,
    input  mode_start
  );
endinterface

// File: rtl/marquee_scheduler.sv
// rtl/marquee_scheduler.sv - marquee mode sequencer with step tick, skip debounce and pause; CHASE mode built only with MARQUEE_CHASE_EN
module marquee_scheduler #(
  parameter int TICK_DIV    = 12500000,
  parameter int DEBOUNCE    = 500000,
  parameter int FILL_STEPS  = 12,
  parameter int BLINK_STEPS = 8,
  parameter int CHASE_STEPS = 24
) (
  input  logic                clk,
  input  logic                reset,
  marquee_scheduler_if.master sched
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    BLINK = 2'd1,
    CHASE = 2'd2
  } mode_t;

  mode_t         mode_q;
  logic [4:0]    idx_q;
  logic          step_q;
  logic          start_q;
  logic [TW-1:0] tick_cnt;

  logic          sync1;
  logic          sync2;
  logic          deb_q;
  logic [DW-1:0] deb_cnt;

  logic          sync_diff;
  logic          deb_done;
  logic          skip_ev;
  logic          tick;

  // Mode that follows m; without CHASE the sequence folds back from BLINK to FILL.
  function automatic mode_t next_mode(input mode_t m);
    case (m)
      FILL:    return BLINK;
`ifdef MARQUEE_CHASE_EN
      BLINK:   return CHASE;
`else
      BLINK:   return FILL;
`endif
      default: return FILL;
    endcase
  endfunction

  // Final step index of mode m; the CHASE arm is unreachable when CHASE is not built.
  function automatic logic [4:0] last_idx(input mode_t m);
    case (m)
      FILL:    return 5'(FILL_STEPS - 1);
      BLINK:   return 5'(BLINK_STEPS - 1);
      default: return 5'(CHASE_STEPS - 1);
    endcase
  endfunction

  assign sync_diff = (sync2 != deb_q);
  assign deb_done  = sync_diff && (deb_cnt == DEB_LAST);
  // Only a press (debounced 1 -> 0) is an event; the release is silent.
  assign skip_ev   = deb_done && deb_q;
  assign tick      = !sched.pause && (tick_cnt == TICK_LAST);

  // Two-flop synchronizer for the raw push-button; idles released (1).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= sched.skip_n;
      sync2 <= sync1;
    end
  end

  // Debounce: the synchronized level must differ for DEBOUNCE cycles before it is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_q   <= 1'b1;
      deb_cnt <= '0;
    end else if (!sync_diff) begin
      deb_cnt <= '0;
    end else if (deb_done) begin
      deb_q   <= sync2;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + DW'(1);
    end
  end

  // Sequencer: tick divider plus mode/index walk; a skip overrides a coincident tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q   <= FILL;
      idx_q    <= 5'd0;
      step_q   <= 1'b0;
      start_q  <= 1'b0;
      tick_cnt <= '0;
    end else begin
      step_q  <= 1'b0;
      start_q <= 1'b0;
      if (skip_ev) begin
        mode_q   <= next_mode(mode_q);
        idx_q    <= 5'd0;
        step_q   <= 1'b1;
        start_q  <= 1'b1;
        tick_cnt <= '0;
      end else if (!sched.pause) begin
        if (tick) begin
          tick_cnt <= '0;
          step_q   <= 1'b1;
          if (idx_q >= last_idx(mode_q)) begin
            mode_q  <= next_mode(mode_q);
            idx_q   <= 5'd0;
            start_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 5'd1;
          end
        end else begin
          tick_cnt <= tick_cnt + TW'(1);
        end
      end
    end
  end

  assign sched.mode       = mode_q;
  assign sched.step_idx   = idx_q;
  assign sched.step       = step_q;
  assign sched.mode_start = start_q;

endmodule

// File: doc/marquee_scheduler.md
# marquee_scheduler

Mode sequencer for the 12-LED marquee board. Runs from the 50 MHz board clock, divides it into a step tick and walks the LED pattern datapath through its modes (FILL, BLINK, CHASE) with a fixed step count per mode. Also debounces a skip push-button and honours a pause switch. Outputs `mode` and `step_idx` select the pattern; `step` tells the pattern datapath when to load the next pattern.

## Interface
Parameters:
- `TICK_DIV`, 12500000: clk cycles per step tick (≥2).
- `DEBOUNCE`, 500000: cycles skip input must stay stable (≥2).
- `FILL_STEPS`, 12: steps in FILL mode (1..31).
- `BLINK_STEPS`, 8: steps in BLINK mode (1..31).
- `CHASE_STEPS`, 24: steps in CHASE mode (1..31).

Ports:
- `clk`  in  1  50 MHz board clock.
- `reset`  in  1  asynchronous, active-low reset.
- `pause`  in  1  level, synchronous; 1 freezes the tick counter.
- `skip_n`  in  1  raw push-button, active-low, asynchronous; synchronized internally.
- `mode`  out  2  current mode: 0 FILL, 1 BLINK, 2 CHASE.
- `step_idx`  out  5  step index within the current mode.
- `step`  out  1  one-cycle pulse; `mode`/`step_idx` took new values this cycle.
- `mode_start`  out  1  one-cycle pulse with `step` when a new mode is entered.

## Operation
- Reset values: `mode`=0, `step_idx`=0, `step`=0, `mode_start`=0, tick counter=0, sync flops=1, debounced state=1 (released), debounce counter=0.
- Tick counter:
  - Counts 0..`TICK_DIV`-1 and wraps.
  - The wrap cycle is a tick.
  - While `pause`=1 the counter holds its value and no tick occurs.
- Steps on a tick, with N = the current mode's step count:
  - If `step_idx` < N-1: `step_idx` increments and `step`=1.
  - If `step_idx` = N-1: `mode` advances to the next mode, `step_idx`=0, `step`=1 and `mode_start`=1.
- Mode order: FILL→BLINK→CHASE→FILL.
- Skip synchronizer and debounce:
  - `skip_n` passes through a 2-flop synchronizer.
  - The debounce counter increments while the synchronized value differs from the debounced state. It clears when they are equal.
  - When the counter equals `DEBOUNCE`-1 and the values still differ, the debounced state takes the new value and the counter clears.
- Skip event:
  - A skip event is a debounced 1→0 transition.
  - It takes effect in the same edge the debounced state falls.
  - Effect: advance `mode`, `step_idx`=0, `step`=1, `mode_start`=1, tick counter cleared to 0.
  - Button release produces no event.
- Skip and tick in the same cycle: the skip wins. There is a single mode advance and the counter is cleared.
- Skip while `pause`=1: the skip is honoured. The counter stays at 0 until the pause is removed.
- Asserting `reset` mid-mode: all state returns to its reset values immediately (asynchronous). Operation restarts in FILL, index 0.
- `step_idx` never exceeds N-1 of the current mode. `mode` never takes the value 3.

## Timing
- All outputs are registered. No combinational path from input to output.
- First step after reset release (pause=0): `step`=1 in the cycle after the `TICK_DIV`-th rising edge. Subsequent steps follow every `TICK_DIV` cycles.
- Pause: removing the pause resumes from the held count. The step period is stretched by exactly the number of paused cycles.
- Skip latency: `skip_n` first sampled low at edge 1. The debounced state falls and `step`/`mode_start` assert at edge `DEBOUNCE`+2, if the low is held throughout.
- After a skip, the next tick comes `TICK_DIV` unpaused cycles later.
- A low pulse on `skip_n` shorter than `DEBOUNCE` synchronized cycles produces no event.
- `step` and `mode_start` are high for exactly one cycle. They are never high on two consecutive cycles unless a tick and a skip occur on adjacent edges.

## Configuration
- `MARQUEE_CHASE_EN` defined:
  - Three-mode sequence FILL→BLINK→CHASE→FILL.
  - `CHASE_STEPS` is used.
- Not defined:
  - CHASE is compiled out. The sequence is FILL→BLINK→FILL and `mode` is never 2.
  - A skip from BLINK goes to FILL.
  - `CHASE_STEPS` is ignored.

## Test plan
Bench settings: `TICK_DIV`=4, `DEBOUNCE`=4, defaults otherwise, `MARQUEE_CHASE_EN` defined unless noted.
- Reset release, pause=0, run 48 cycles:
  - `step` pulses every 4 cycles. `step_idx` goes 1..11.
  - On the 12th step: `mode`=1, `step_idx`=0, `mode_start`=1.
- Full cycle:
  - After 12+8+24 steps, `mode` returns to 0.
  - `mode_start` pulses exactly 3 times. `mode` is never 3.
- Pause for 10 cycles mid-count at counter=2: the next `step` arrives exactly 10 cycles late.
- Skip press:
  - Hold `skip_n` low for 8 cycles in FILL at `step_idx`=5 → at edge 6, `mode`=1, `step_idx`=0, `step`=`mode_start`=1.
  - The next step follows 4 cycles later.
- Glitch: drive `skip_n` low for 2 cycles → no mode change.
- Skip coincident with tick at BLINK `step_idx`=7 → a single advance to `mode`=2. Then, with `MARQUEE_CHASE_EN` undefined, the same stimulus → `mode`=0.
- Async `reset` asserted mid-CHASE between clock edges → `mode`=0, `step_idx`=0, `step`=0 immediately.
